// File: rtl/mat_input_skewer.sv
// Diagonal skewer feeding MatUnit: lane i of each accepted row reaches data_out i cycles after lane 0,
// with the weight-row latch strobe aligned to the last lane of every weight row.
module mat_input_skewer #(
   parameter int N     = 4,
   parameter int ROW_W = $clog2(N)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*32-1:0]    in_vec,
   input  logic               in_weight,
   input  logic               hold,
   output logic [N*32-1:0]    data_out,
   output logic               set_weight,
   output logic [ROW_W-1:0]   set_weight_row,
   output logic               busy,
   output logic               err_partial
);

   logic               started_q;
   logic               accept;
   logic               take_w;
   logic [N:0]         vld_q;
   logic [N:0]         wgt_q;
   logic [ROW_W-1:0]   row_q [N];
   logic [ROW_W-1:0]   wrow_q;
   logic [ROW_W-1:0]   swrow_q;
   logic               err_pend_q;
   logic               err_q;

   assign in_ready = started_q & ~hold;
   assign accept   = in_valid & in_ready;
   assign take_w   = accept & in_weight;

   // Tag chain stage k lines up with the lane stage written k edges after the accept;
   // stage N coincides with lane N-1 on data_out.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         started_q  <= 1'b0;
         vld_q      <= '0;
         wgt_q      <= '0;
         wrow_q     <= '0;
         swrow_q    <= '0;
         err_pend_q <= 1'b0;
         err_q      <= 1'b0;
         for (int k = 0; k < N; k++) row_q[k] <= '0;
      end else begin
         started_q <= 1'b1;
         if (!hold) begin
            vld_q    <= {vld_q[N-1:0], accept};
            wgt_q    <= {wgt_q[N-1:0], take_w};
            row_q[0] <= wrow_q;
            for (int k = 1; k < N; k++) row_q[k] <= row_q[k-1];
            if (vld_q[N-1] & wgt_q[N-1]) swrow_q <= row_q[N-1];
            if (take_w)
               wrow_q <= (wrow_q == ROW_W'(N-1)) ? '0 : wrow_q + ROW_W'(1);
            else if (accept)
               wrow_q <= '0;
            err_pend_q <= accept & ~in_weight & (wrow_q != '0);
            err_q      <= err_pend_q;
         end
      end
   end

   assign set_weight     = vld_q[N] & wgt_q[N];
   assign set_weight_row = swrow_q;
   assign busy           = |vld_q[N:1];
   assign err_partial    = err_q & ~hold;

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [31:0] stg_q [i+1];
      logic [31:0] out_q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 0; k <= i; k++) stg_q[k] <= '0;
            out_q <= '0;
         end else if (!hold) begin
            stg_q[0] <= accept ? in_vec[32*i +: 32] : 32'h0;
            for (int k = 1; k <= i; k++) stg_q[k] <= stg_q[k-1];
            out_q <= stg_q[i];
         end
      end

      assign data_out[32*i +: 32] = out_q;
   end

endmodule

// File: tb/tb_mat_input_skewer.sv
// Bench for mat_input_skewer: directed table plus randomized traffic against an event-history model.
module tb_mat_input_skewer;
   localparam int N = 4;
   localparam logic [31:0] Z  = 32'h0000_0000;
   localparam logic [31:0] F1 = 32'h3F80_0000;
   localparam logic [31:0] F2 = 32'h4000_0000;
   localparam logic [31:0] F3 = 32'h4040_0000;
   localparam logic [31:0] F4 = 32'h4080_0000;
   localparam logic [31:0] F5 = 32'h40A0_0000;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [127:0]   in_vec = '0;
   logic           in_weight = 1'b0;
   logic           hold = 1'b0;
   logic [127:0]   data_out;
   logic           set_weight;
   logic [1:0]     set_weight_row;
   logic           busy;
   logic           err_partial;

   mat_input_skewer #(.N(N)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .in_weight(in_weight), .hold(hold), .data_out(data_out),
      .set_weight(set_weight), .set_weight_row(set_weight_row), .busy(busy),
      .err_partial(err_partial)
   );

   always #5 clock = ~clock;

   int n_pass = 0;
   int n_total = 0;

   // Reference: history of what entered the pipeline at each advancing edge (index 0 = newest).
   typedef struct {
      logic [127:0] vec;
      bit           v;
      bit           w;
      logic [1:0]   row;
      bit           err;
   } ent_t;

   ent_t       hist [0:N];
   bit         started_m;
   int         wrow_m;
   logic [1:0] swrow_m;

   typedef struct {
      bit           rst;
      bit           v;
      bit           w;
      bit           h;
      logic [127:0] vin;
      bit           cd;
      logic [127:0] edo;
      bit           esw;
      logic [1:0]   erow;
      bit           ebusy;
      bit           eerr;
   } row_t;

   row_t tbl [$];

   function automatic logic [127:0] fv(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
      return {d, c, b, a};
   endfunction

   function automatic logic [31:0] wl(int k, int i);
      return 32'hA000_0000 + 32'(k * 16 + i);
   endfunction

   function automatic logic [127:0] wv(int k);
      return fv(wl(k, 0), wl(k, 1), wl(k, 2), wl(k, 3));
   endfunction

   function automatic row_t mk(bit rst, bit v, bit w, bit h, logic [127:0] vin, bit cd,
                               logic [127:0] edo, bit esw, logic [1:0] erow, bit ebusy, bit eerr);
      row_t r;
      r.rst = rst; r.v = v; r.w = w; r.h = h; r.vin = vin; r.cd = cd;
      r.edo = edo; r.esw = esw; r.erow = erow; r.ebusy = ebusy; r.eerr = eerr;
      return r;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   task automatic model_clear();
      started_m = 1'b0;
      wrow_m = 0;
      swrow_m = 2'd0;
      for (int k = 0; k <= N; k++) begin
         hist[k].vec = '0; hist[k].v = 1'b0; hist[k].w = 1'b0;
         hist[k].row = 2'd0; hist[k].err = 1'b0;
      end
   endtask

   task automatic check_model();
      logic [127:0] edo;
      bit eb;
      eb = 1'b0;
      for (int i = 0; i < N; i++) edo[32*i +: 32] = hist[i+1].vec[32*i +: 32];
      for (int k = 1; k <= N; k++) eb |= hist[k].v;
      chk("m_data", data_out, edo);
      chk("m_busy", busy, eb);
      chk("m_sw", set_weight, hist[N].v && hist[N].w);
      chk("m_row", set_weight_row, swrow_m);
      chk("m_err", err_partial, hist[1].err && !hold);
      chk("m_rdy", in_ready, started_m && !hold);
   endtask

   // One clock edge with the current inputs; model advances alongside, then outputs are compared.
   task automatic step();
      bit   acc;
      ent_t e;
      acc = started_m && !hold && in_valid;
      @(posedge clock);
      if (reset_n) begin
         if (!hold) begin
            e.vec = acc ? in_vec : '0;
            e.v   = acc;
            e.w   = acc && in_weight;
            e.row = 2'(wrow_m);
            e.err = acc && !in_weight && (wrow_m != 0);
            for (int k = N; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = e;
            if (hist[N].v && hist[N].w) swrow_m = hist[N].row;
            if (acc) wrow_m = in_weight ? (wrow_m + 1) % N : 0;
         end
         started_m = 1'b1;
      end
      #1;
      check_model();
   endtask

   task automatic do_reset();
      in_valid  = 1'($urandom);
      in_weight = 1'($urandom);
      hold      = 1'($urandom);
      in_vec    = {$urandom, $urandom, $urandom, $urandom};
      reset_n   = 1'b0;
      #2;
      model_clear();
      chk("rst_data", data_out, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sw", set_weight, 1'b0);
      chk("rst_rdy", in_ready, 1'b0);
      @(posedge clock);
      #1;
      chk("rst_edge_data", data_out, '0);
      chk("rst_edge_err", err_partial, 1'b0);
      chk("rst_edge_row", set_weight_row, 2'd0);
      reset_n = 1'b1;
      #1;
      chk("rel_rdy_before_edge", in_ready, 1'b0);
      in_valid = 1'b0;
      hold = 1'b0;
      step();
      chk("rel_rdy_after_edge", in_ready, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();

      // compute row, then idle
      tbl.push_back(mk(1, 1, 0, 0, fv(F1, F2, F3, F4), 1, '0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(F1, Z, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, F2, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, F3, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, Z, F4), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, '0, 0, 0, 0, 0));
      // four weight rows back-to-back
      tbl.push_back(mk(1, 1, 1, 0, wv(0), 1, '0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, wv(1), 1, fv(wl(0,0), Z, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, wv(2), 1, fv(wl(1,0), wl(0,1), Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, wv(3), 1, fv(wl(2,0), wl(1,1), wl(0,2), Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(wl(3,0), wl(2,1), wl(1,2), wl(0,3)), 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, wl(3,1), wl(2,2), wl(1,3)), 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, wl(3,2), wl(2,3)), 1, 2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, Z, wl(3,3)), 1, 3, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, '0, 0, 3, 0, 0));
      // back-to-back compute rows, no bubble between them
      tbl.push_back(mk(1, 1, 0, 0, fv(F5, F5, F5, F5), 1, '0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, fv(F1, Z, F1, Z), 1, fv(F5, Z, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(F1, F5, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, F5, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, F1, F5), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, '0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, '0, 0, 0, 0, 0));
      // hold for two cycles mid-stream, including a blocked valid
      tbl.push_back(mk(1, 1, 0, 0, fv(F1, F2, F3, F4), 1, '0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(F1, Z, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, F2, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, '0, 1, fv(Z, F2, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 1, fv(F5, F5, F5, F5), 1, fv(Z, F2, Z, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, F3, Z), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, fv(Z, Z, Z, F4), 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 1, '0, 0, 0, 0, 0));
      // partial weight load aborted by compute, then a weight row restarts at row 0
      tbl.push_back(mk(1, 1, 1, 0, wv(4), 0, '0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, wv(5), 0, '0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, fv(F1, F2, F3, F4), 0, '0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 0, '0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 1, 1, 0, wv(6), 0, '0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 0, '0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 0, '0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 0, '0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 0, '0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, '0, 0, '0, 0, 0, 0, 0));

      foreach (tbl[j]) begin
         if (tbl[j].rst) do_reset();
         in_valid  = tbl[j].v;
         in_weight = tbl[j].w;
         hold      = tbl[j].h;
         in_vec    = tbl[j].vin;
         step();
         if (tbl[j].cd) chk($sformatf("tbl%0d_data", j), data_out, tbl[j].edo);
         chk($sformatf("tbl%0d_sw", j), set_weight, tbl[j].esw);
         chk($sformatf("tbl%0d_row", j), set_weight_row, tbl[j].erow);
         chk($sformatf("tbl%0d_busy", j), busy, tbl[j].ebusy);
         chk($sformatf("tbl%0d_err", j), err_partial, tbl[j].eerr);
      end

      // reset asserted while data is in flight
      do_reset();
      in_valid = 1'b1; in_weight = 1'b0; in_vec = fv(F1, F2, F3, F4);
      step();
      in_weight = 1'b1; in_vec = wv(7);
      step();
      in_valid = 1'b0;
      step();
      chk("mr_busy_before", busy, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mr_data", data_out, '0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_sw", set_weight, 1'b0);
      model_clear();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step();
      in_valid = 1'b1; in_weight = 1'b1; in_vec = wv(8);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) step();

      // randomized traffic, checked by the model every cycle
      do_reset();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_weight = ($urandom_range(0, 2) != 0);
         hold      = ($urandom_range(0, 7) == 0);
         in_vec    = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      in_valid = 1'b0;
      hold = 1'b0;
      for (int c = 0; c < N + 2; c++) step();
      chk("drain_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
